// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory bus bundle for the two-port data memory arbiter
// Requester fields are packed per port (port p in slice p); memory side is a single word port.

interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]      req;
    logic [1:0]      we;
    logic [3:0]      size;
    logic [1:0]      uns;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic [1:0]      err;
    logic [DW-1:0]   rdata;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  req, we, size, uns, addr, wdata, mem_rdata,
        output gnt, done, err, rdata, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req, we, size, uns, addr, wdata, mem_rdata,
        input  gnt, done, err, rdata, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter onto a single-cycle data memory
// One transaction in flight: IDLE (grant) -> ISSUE (memory access) -> DONE (completion pulse).

module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    port_q, port_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    win;
    logic                    legal;
    logic [3:0]              lane_be;
    logic [DATA_WIDTH-1:0]   store_word;
    logic [DATA_WIDTH-1:0]   lane_shift;
    logic [DATA_WIDTH-1:0]   load_ext;

    logic [1:0]              gnt_c, done_c, err_c;
    logic                    mem_we_c;
    logic [3:0]              mem_be_c;

    // Sole requester wins outright; on contention the port not granted last wins.
    always_comb begin
        win = bus.req[1];
        if (bus.req == 2'b11) begin
            win = ~last_q;
        end
    end

    always_comb begin
        legal = 1'b0;
        case (size_q)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~addr_q[0];
            2'b10:   legal = (addr_q[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        lane_be    = 4'b0000;
        store_word = wdata_q;
        case (size_q)
            2'b00: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                store_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                store_word = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                lane_be    = 4'b1111;
                store_word = wdata_q;
            end
            default: begin
                lane_be    = 4'b0000;
                store_word = wdata_q;
            end
        endcase
        if (!legal) begin
            lane_be = 4'b0000;
        end
    end

    // Legal halves are 2-byte aligned, so shifting by the full byte offset lands either lane pair.
    always_comb begin
        lane_shift = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        load_ext   = bus.mem_rdata;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h000000, lane_shift[7:0]}
                                      : {{24{lane_shift[7]}}, lane_shift[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0000, lane_shift[15:0]}
                                      : {{16{lane_shift[15]}}, lane_shift[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        port_d   = port_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        gnt_c    = 2'b00;
        done_c   = 2'b00;
        err_c    = 2'b00;
        mem_we_c = 1'b0;
        mem_be_c = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    gnt_c   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    port_d  = win;
                    we_d    = bus.we[win];
                    size_d  = win ? bus.size[3:2] : bus.size[1:0];
                    uns_d   = bus.uns[win];
                    addr_d  = win ? bus.addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : bus.addr[ADDR_WIDTH-1:0];
                    wdata_d = win ? bus.wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : bus.wdata[DATA_WIDTH-1:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_be_c = lane_be;
                mem_we_c = we_q & legal;
                rdata_d  = (!we_q && legal) ? load_ext : '0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done_c  = port_q ? 2'b10 : 2'b01;
                err_c   = legal ? 2'b00 : done_c;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset edge must not see a grant, a completion or a memory write.
        if (rst) begin
            gnt_c    = 2'b00;
            done_c   = 2'b00;
            err_c    = 2'b00;
            mem_we_c = 1'b0;
            mem_be_c = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.done      = done_c;
    assign bus.err       = err_c;
    assign bus.rdata     = rdata_q;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_be    = mem_be_c;
    assign bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata = store_word;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Byte-addressed reference memory and round-robin model predict every grant, strobe and result.

module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] tb_mem [16];
    logic [7:0]  ref_b  [64];
    assign bus.mem_rdata = tb_mem[bus.mem_addr[5:2]];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        p_pend  [2];
    logic        p_we    [2];
    logic        p_uns   [2];
    logic [1:0]  p_size  [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic        model_last;

    logic [1:0]  obs_gnt, obs_err;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    int          gnt_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit legal(input logic [1:0] sz, input logic [31:0] ad);
        return (sz == 2'd0) || (sz == 2'd1 && ad[0] == 1'b0) || (sz == 2'd2 && ad[1:0] == 2'd0);
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] ad);
        logic [3:0] be = 4'b0000;
        if (legal(sz, ad))
            for (int k = 0; k < nbytes(sz); k++) be[int'(ad[1:0]) + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic u, input logic [31:0] ad);
        int a = int'(ad[5:0]);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_b[a + k];
        if (!u && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic poke(input int idx, input logic [31:0] v);
        tb_mem[idx] = v;
        for (int k = 0; k < 4; k++) ref_b[4*idx + k] = v[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    task automatic drive();
        bus.req   = {p_pend[1], p_pend[0]};
        bus.we    = {p_we[1], p_we[0]};
        bus.size  = {p_size[1], p_size[0]};
        bus.uns   = {p_uns[1], p_uns[0]};
        bus.addr  = {p_addr[1], p_addr[0]};
        bus.wdata = {p_wdata[1], p_wdata[0]};
    endtask

    task automatic set_port(input int p, input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] ad, input logic [31:0] wd);
        p_pend[p] = 1'b1; p_we[p] = w; p_size[p] = sz; p_uns[p] = u;
        p_addr[p] = ad;   p_wdata[p] = wd;
    endtask

    task automatic rand_port(input int p);
        int r = $urandom_range(0, 9);
        logic [1:0] sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        logic [31:0] ad = 32'h10000 + $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) ad[0] = 1'b0;
            if (sz == 2'd2) ad[1:0] = 2'b00;
        end
        set_port(p, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p_pend[0] = 1'b0; p_pend[1] = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1'b1;
        #1;
    endtask

    // One full transaction: grant in the current IDLE cycle, then ISSUE, DONE, back to IDLE.
    task automatic issue();
        int win, k;
        logic lg, w;
        logic [1:0] sz;
        logic [31:0] ad, er;
        drive();
        #1;
        k = 0;
        while (bus.gnt == 2'b00 && k < 4) begin
            @(posedge clk); #1; k++;
        end
        win = (p_pend[0] && p_pend[1]) ? (model_last ? 0 : 1) : (p_pend[1] ? 1 : 0);
        obs_gnt = bus.gnt;
        gnt_cyc = cyc;
        check("gnt", bus.gnt, 32'(1 << win));
        if (bus.gnt == 2'b00) return;
        model_last = win[0];
        p_pend[win] = 1'b0;
        w = p_we[win]; sz = p_size[win]; ad = p_addr[win];
        lg = legal(sz, ad);
        er = (!w && lg) ? exp_load(sz, p_uns[win], ad) : 32'h0;

        @(posedge clk); #1;
        drive();
        check("mem_we", bus.mem_we, w && lg);
        check("mem_be", bus.mem_be, exp_be(sz, ad));
        check("done_in_issue", bus.done, 0);
        if (lg) check("mem_addr", bus.mem_addr, {ad[31:2], 2'b00});
        obs_be = bus.mem_be;
        obs_wdata = bus.mem_wdata;
        if (bus.mem_we)
            for (int i = 0; i < 4; i++)
                if (bus.mem_be[i]) tb_mem[bus.mem_addr[5:2]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
        if (w && lg)
            for (int i = 0; i < nbytes(sz); i++) ref_b[int'(ad[5:0]) + i] = p_wdata[win][8*i +: 8];

        @(posedge clk); #1;
        check("done", bus.done, 32'(1 << win));
        check("err", bus.err, lg ? 0 : 32'(1 << win));
        check("rdata", bus.rdata, er);
        check("mem_we_idle", bus.mem_we, 0);
        check("mem_be_idle", bus.mem_be, 0);
        obs_err = bus.err;
        @(posedge clk); #1;
        check("done_clear", bus.done, 0);
    endtask

    initial begin
        int last_cyc;
        logic [1:0] gseq [4];
        logic [31:0] keep;
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        p_pend[0] = 1'b0; p_pend[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            p_we[p] = 1'b0; p_uns[p] = 1'b0; p_size[p] = 2'd0;
            p_addr[p] = 32'h0; p_wdata[p] = 32'h0;
        end
        do_reset();
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_be", bus.mem_be, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);

        set_port(0, 1'b1, 2'd2, 1'b0, 32'h10000, 32'hDEADBEEF);
        issue();
        check("w_store_be", obs_be, 4'hF);
        check("w_store_mem", tb_mem[0], 32'hDEADBEEF);

        poke(0, 32'h80FF00AA);
        set_port(1, 1'b0, 2'd0, 1'b0, 32'h10003, 32'h0);
        issue();
        check("ld_byte_sext", bus.rdata, 32'hFFFFFF80);
        set_port(1, 1'b0, 2'd0, 1'b1, 32'h10003, 32'h0);
        issue();
        check("ld_byte_zext", bus.rdata, 32'h00000080);

        set_port(0, 1'b1, 2'd1, 1'b0, 32'h10002, 32'h00001234);
        issue();
        check("half_be", obs_be, 4'hC);
        check("half_wdata", obs_wdata, 32'h12341234);

        set_port(0, 1'b1, 2'd2, 1'b0, 32'h10001, 32'h55AA55AA);
        issue();
        check("misalign_err", obs_err, 2'b01);
        check("misalign_be", obs_be, 4'h0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (!p_pend[0]) set_port(0, 1'b0, 2'd2, 1'b0, 32'h10000 + 4*i, 32'h0);
            if (!p_pend[1]) set_port(1, 1'b0, 2'd2, 1'b0, 32'h10010 + 4*i, 32'h0);
            issue();
            gseq[i] = obs_gnt;
            if (i > 0) check("gnt_gap", gnt_cyc - last_cyc, 3);
            last_cyc = gnt_cyc;
        end
        check("rr_seq", {gseq[0], gseq[1], gseq[2], gseq[3]}, 8'b01_10_01_10);

        p_pend[0] = 1'b0; p_pend[1] = 1'b0;
        keep = ref_word(1);
        set_port(0, 1'b1, 2'd2, 1'b0, 32'h10004, ~keep);
        drive();
        #1;
        check("abort_gnt", bus.gnt, 2'b01);
        @(posedge clk); #1;
        p_pend[0] = 1'b0;
        drive();
        rst = 1'b1;
        #1;
        check("abort_mem_we", bus.mem_we, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b1;
        #1;
        check("abort_done", bus.done, 0);
        check("abort_gnt_clr", bus.gnt, 0);
        check("abort_err", bus.err, 0);
        check("abort_rdata", bus.rdata, 0);
        check("abort_mem_we2", bus.mem_we, 0);
        check("abort_mem_be", bus.mem_be, 0);
        check("abort_mem_addr", bus.mem_addr, 0);
        check("abort_mem_wdata", bus.mem_wdata, 0);
        check("abort_mem_kept", tb_mem[1], keep);
        @(posedge clk); #1;
        check("abort_no_done", bus.done, 0);

        for (int r = 0; r < 150; r++) begin
            for (int p = 0; p < 2; p++)
                if (!p_pend[p] && $urandom_range(0, 1) == 1) rand_port(p);
            if (!p_pend[0] && !p_pend[1]) rand_port($urandom_range(0, 1));
            issue();
        end
        for (int i = 0; i < 16; i++) check("final_mem", tb_mem[i], ref_word(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, is the byte address width.
REQ-002 Parameter DATA_WIDTH, default 32, is the data word width; only 32 is supported.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req  input  2  carries per-port request; bit 0 is the CPU load/store port, bit 1 is the DMA/loader port.
REQ-006 we  input  2  is the per-port write enable; 1 means store, 0 means load.
REQ-007 size  input  4  carries 2 bits per port (port p at [2p+1:2p]): 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 uns  input  2  is the per-port load zero-extend select; 0 means sign-extend.
REQ-009 addr  input  2*ADDR_WIDTH  is the per-port byte address; port p is at slice p.
REQ-010 wdata  input  2*DATA_WIDTH  is the per-port store data, LSB-aligned; port p is at slice p.
REQ-011 gnt  output  2  is a one-hot, one-cycle pulse: request accepted.
REQ-012 done  output  2  is a one-hot, one-cycle pulse: transaction complete.
REQ-013 err  output  2  is valid with done: the access was misaligned or used the reserved size.
REQ-014 rdata  output  DATA_WIDTH  is the extended load result, valid with done on a load.
REQ-015 mem_we  output  1  is the memory write strobe.
REQ-016 mem_be  output  4  is the byte-lane enables; lane i is bits [8i+7:8i].
REQ-017 mem_addr  output  ADDR_WIDTH  is the word-aligned address, with bits [1:0] forced to 00.
REQ-018 mem_wdata  output  DATA_WIDTH  is the lane-replicated store data.
REQ-019 mem_rdata  input  DATA_WIDTH  is the combinational read word at mem_addr.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE and DONE, with exactly one transaction outstanding.
REQ-021 In IDLE with any req high, the arbiter SHALL pulse gnt for the winner, capture its we/size/uns/addr/wdata, and go to ISSUE.
REQ-022 Arbitration SHALL be round-robin via a last-grant register: on contention the port not granted last wins; a sole requester always wins.
REQ-023 Requesters SHALL hold req until gnt; a non-granted req SHALL be ignored in ISSUE/DONE and re-arbitrated in the next IDLE.
REQ-024 ISSUE SHALL last one cycle: drive mem_addr/mem_be/mem_wdata from the captured request, assert mem_we for a legal store, register the load result, then go to DONE.
REQ-025 DONE SHALL last one cycle: pulse done (and err if illegal) for the captured port, then go to IDLE.
REQ-026 Latency SHALL be gnt at cycle N, memory access at N+1, done at N+2, next gnt no earlier than N+3.
REQ-027 Byte-lane enables SHALL be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111.
REQ-028 Store data SHALL be replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
REQ-029 A load SHALL select the lane(s) by addr[1:0] and extend to 32 bits, sign or zero per uns.
REQ-030 The access SHALL be illegal when size=11, a half has addr[0]=1, or a word has addr[1:0]!=00; illegal access forces mem_we=0, mem_be=0000, rdata=0, err=1.
REQ-031 Outside ISSUE, mem_we SHALL be 0 and mem_be SHALL be 0000; rdata SHALL hold its last value except that reset clears it.
REQ-032 A store SHALL set rdata to 0 at done.

Reset
REQ-033 Reset SHALL force the IDLE state, last-grant=port 1 (so port 0 wins the first contention), gnt=00, done=00, err=00, rdata=0, mem_we=0, mem_be=0000, mem_addr=0 and mem_wdata=0.
REQ-034 Reset asserted in ISSUE or DONE SHALL abort the transaction: no done pulse and no memory write on that edge.

Verification
REQ-035 Port 0 stores word 0xDEADBEEF at 0x10000 -> gnt=01 at N, mem_we=1 and mem_be=1111 at N+1, done=01 and err=0 at N+2.
REQ-036 Port 1 loads a byte at 0x10003 with uns=0 while mem_rdata=0x80FF00AA -> rdata=0xFFFFFF80 at done; the same with uns=1 -> 0x00000080.
REQ-037 Port 0 stores half 0x1234 at 0x10002 -> mem_be=1100 and mem_wdata=0x12341234.
REQ-038 Both ports request continuously after reset -> gnt sequence 01, 10, 01, 10, with gnt pulses 3 cycles apart.
REQ-039 Port 0 stores a word at 0x10001 -> mem_we=0 throughout, done=01 and err=01 at N+2.
REQ-040 rst is asserted during ISSUE of a store -> no mem_we, no done, and all outputs at reset values on the next cycle.
